// File: rtl/uart_host_sequencer_pkg.sv
// Shared types and constants for the UART register-bus host sequencer:
// register map addresses, command opcodes, status field positions and FSM states.
package uart_host_sequencer_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned CMD_W  = 24;
    localparam int unsigned ERR_W  = 4;
    localparam int unsigned CNT_W  = 8;

    // UART controller register map
    localparam logic [ADDR_W-1:0] ADDR_STR  = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_LDVR = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_UDVR = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_FSR  = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_ISR  = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_RXR  = 3'd6;
    localparam logic [ADDR_W-1:0] ADDR_TXR  = 3'd7;

    localparam logic [DATA_W-1:0] ISR_IACK = 8'h01;

    // Status register field positions
    localparam int unsigned FSR_TXF   = 7;
    localparam int unsigned ISR_RXRDY = 7;
    localparam int unsigned ISR_FRM   = 6;
    localparam int unsigned ISR_PAR   = 5;
    localparam int unsigned ISR_OVR   = 4;

    // Response error bit indices: {TIMEOUT, FRM, PAR, OVR}
    localparam int unsigned ERR_TIMEOUT = 3;
    localparam int unsigned ERR_FRM     = 2;
    localparam int unsigned ERR_PAR     = 1;
    localparam int unsigned ERR_OVR     = 0;

    typedef enum logic [1:0] {
        OP_CONFIG    = 2'd0,
        OP_SEND      = 2'd1,
        OP_THRESHOLD = 2'd2,
        OP_READ      = 2'd3
    } cmd_op_e;

    // CONFIG payload layout; other opcodes use the low bits
    typedef struct packed {
        logic [7:0]  str;
        logic [15:0] div;
    } cmd_payload_t;

    typedef enum logic [3:0] {
        S_IDLE, S_WR_LDVR, S_WR_UDVR, S_WR_STR, S_RD_FSR, S_CHK_FSR, S_WR_TXR,
        S_WR_FSR, S_RD_RXR, S_CHK_RXR, S_RD_ISR, S_CHK_ISR, S_ACK_ISR, S_RESP
    } state_e;

endpackage

// File: rtl/uart_host_sequencer_if.sv
// Command, register-bus and response signals of the host sequencer.
// master = sequencer side, slave = client/controller/bench side.
interface uart_host_sequencer_if;
    import uart_host_sequencer_pkg::*;

    logic                cmd_valid_i;
    logic                cmd_ready_o;
    cmd_op_e             cmd_op_i;
    logic [CMD_W-1:0]    cmd_data_i;
    logic [ADDR_W-1:0]   address_o;
    logic                write_o;
    logic                read_o;
    logic [DATA_W-1:0]   wdata_o;
    logic [DATA_W-1:0]   rdata_i;
    logic                irq_i;
    logic                rsp_valid_o;
    logic                rsp_ready_i;
    logic [DATA_W-1:0]   rsp_data_o;
    logic                rsp_irq_o;
    logic [ERR_W-1:0]    rsp_err_o;

    modport master (
        input  cmd_valid_i, cmd_op_i, cmd_data_i, rdata_i, irq_i, rsp_ready_i,
        output cmd_ready_o, address_o, write_o, read_o, wdata_o,
               rsp_valid_o, rsp_data_o, rsp_irq_o, rsp_err_o
    );

    modport slave (
        output cmd_valid_i, cmd_op_i, cmd_data_i, rdata_i, irq_i, rsp_ready_i,
        input  cmd_ready_o, address_o, write_o, read_o, wdata_o,
               rsp_valid_o, rsp_data_o, rsp_irq_o, rsp_err_o
    );
endinterface

// File: rtl/uart_host_sequencer.sv
// Register-bus master for the UART controller: turns client commands into
// register read/write sequences and services the controller interrupt.
module uart_host_sequencer
    import uart_host_sequencer_pkg::*;
#(
    parameter int unsigned POLL_LIMIT = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    uart_host_sequencer_if.master bus
);

    state_e            state_q, state_d;
    cmd_payload_t      cmd_q, cmd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              irq_mode_q, irq_mode_d;
    logic              run_q;
    logic [CNT_W:0]    polls_c;

    assign polls_c = {1'b0, cnt_q} + (CNT_W+1)'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cmd_q      <= '0;
            cnt_q      <= '0;
            rx_q       <= '0;
            err_q      <= '0;
            irq_mode_q <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            cnt_q      <= cnt_d;
            rx_q       <= rx_d;
            err_q      <= err_d;
            irq_mode_q <= irq_mode_d;
            run_q      <= 1'b1;
        end
    end

    always_comb begin
        state_d         = state_q;
        cmd_d           = cmd_q;
        cnt_d           = cnt_q;
        rx_d            = rx_q;
        err_d           = err_q;
        irq_mode_d      = irq_mode_q;
        bus.cmd_ready_o = run_q && (state_q == S_IDLE) && !bus.irq_i;
        bus.address_o   = '0;
        bus.write_o     = 1'b0;
        bus.read_o      = 1'b0;
        bus.wdata_o     = '0;
        bus.rsp_valid_o = 1'b0;
        bus.rsp_data_o  = '0;
        bus.rsp_irq_o   = 1'b0;
        bus.rsp_err_o   = '0;

        unique case (state_q)
            // Interrupt wins over a pending command; irq is only looked at here
            S_IDLE: begin
                if (run_q && bus.irq_i) begin
                    state_d    = S_RD_ISR;
                    irq_mode_d = 1'b1;
                    rx_d       = '0;
                    err_d      = '0;
                end else if (run_q && bus.cmd_valid_i) begin
                    cmd_d      = bus.cmd_data_i;
                    cnt_d      = '0;
                    rx_d       = '0;
                    err_d      = '0;
                    irq_mode_d = 1'b0;
                    unique case (bus.cmd_op_i)
                        OP_CONFIG:    state_d = S_WR_LDVR;
                        OP_SEND:      state_d = S_RD_FSR;
                        OP_THRESHOLD: state_d = S_WR_FSR;
                        OP_READ:      state_d = S_RD_RXR;
                        default:      state_d = S_IDLE;
                    endcase
                end
            end
            S_WR_LDVR: begin
                bus.write_o   = 1'b1;
                bus.address_o = ADDR_LDVR;
                bus.wdata_o   = cmd_q.div[7:0];
                state_d       = S_WR_UDVR;
            end
            S_WR_UDVR: begin
                bus.write_o   = 1'b1;
                bus.address_o = ADDR_UDVR;
                bus.wdata_o   = cmd_q.div[15:8];
                state_d       = S_WR_STR;
            end
            S_WR_STR: begin
                bus.write_o   = 1'b1;
                bus.address_o = ADDR_STR;
                bus.wdata_o   = cmd_q.str;
                state_d       = S_IDLE;
            end
            S_WR_FSR: begin
                bus.write_o   = 1'b1;
                bus.address_o = ADDR_FSR;
                bus.wdata_o   = {2'b00, cmd_q[5:0]};
                state_d       = S_IDLE;
            end
            S_RD_FSR: begin
                bus.read_o    = 1'b1;
                bus.address_o = ADDR_FSR;
                state_d       = S_CHK_FSR;
            end
            // TX FIFO full: poll again until the limit, then report a timeout
            S_CHK_FSR: begin
                if (!bus.rdata_i[FSR_TXF]) begin
                    state_d = S_WR_TXR;
                end else begin
                    if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                    if (polls_c >= (CNT_W+1)'(POLL_LIMIT)) begin
                        state_d            = S_RESP;
                        err_d              = '0;
                        err_d[ERR_TIMEOUT] = 1'b1;
                        rx_d               = '0;
                    end else begin
                        state_d = S_RD_FSR;
                    end
                end
            end
            S_WR_TXR: begin
                bus.write_o   = 1'b1;
                bus.address_o = ADDR_TXR;
                bus.wdata_o   = cmd_q[7:0];
                state_d       = S_IDLE;
            end
            S_RD_RXR: begin
                bus.read_o    = 1'b1;
                bus.address_o = ADDR_RXR;
                state_d       = S_CHK_RXR;
            end
            S_CHK_RXR: begin
                rx_d    = bus.rdata_i;
                state_d = irq_mode_q ? S_ACK_ISR : S_RESP;
            end
            S_RD_ISR: begin
                bus.read_o    = 1'b1;
                bus.address_o = ADDR_ISR;
                state_d       = S_CHK_ISR;
            end
            S_CHK_ISR: begin
                err_d[ERR_FRM] = bus.rdata_i[ISR_FRM];
                err_d[ERR_PAR] = bus.rdata_i[ISR_PAR];
                err_d[ERR_OVR] = bus.rdata_i[ISR_OVR];
                state_d        = bus.rdata_i[ISR_RXRDY] ? S_RD_RXR : S_ACK_ISR;
            end
            S_ACK_ISR: begin
                bus.write_o   = 1'b1;
                bus.address_o = ADDR_ISR;
                bus.wdata_o   = ISR_IACK;
                state_d       = S_RESP;
            end
            S_RESP: begin
                bus.rsp_valid_o = 1'b1;
                bus.rsp_data_o  = rx_q;
                bus.rsp_irq_o   = irq_mode_q;
                bus.rsp_err_o   = err_q;
                if (bus.rsp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_host_sequencer.sv
// Scoreboard bench for uart_host_sequencer: stimulus queues expected bus
// strobes and responses with their cycle numbers; monitors pop and compare.
module tb_uart_host_sequencer;
    import uart_host_sequencer_pkg::*;

    localparam int unsigned TB_POLL = 4;

    typedef struct {
        int         cyc;
        bit         wr;
        logic [2:0] addr;
        logic [7:0] data;
    } bus_ev_t;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic [3:0] err;
        logic       irq;
    } rsp_ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    bus_ev_t    bus_q[$];
    rsp_ev_t    rsp_q[$];
    logic [7:0] rd_q[$];
    bus_ev_t    mon_b;
    rsp_ev_t    mon_r;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_host_sequencer_if bus_if();

    uart_host_sequencer #(.POLL_LIMIT(TB_POLL)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic push_bus(input int c, input bit wr, input logic [2:0] a, input logic [7:0] d);
        bus_ev_t e;
        e.cyc = c; e.wr = wr; e.addr = a; e.data = d;
        bus_q.push_back(e);
    endtask

    task automatic push_rsp(input int c, input logic [7:0] d, input logic [3:0] err, input logic irq);
        rsp_ev_t e;
        e.cyc = c; e.data = d; e.err = err; e.irq = irq;
        rsp_q.push_back(e);
    endtask

    // Present a command; returns the cycle in which it was accepted
    task automatic issue(input cmd_op_e op, input logic [23:0] d, output int c0);
        int n;
        n = 0;
        bus_if.cmd_valid_i = 1'b1;
        bus_if.cmd_op_i    = op;
        bus_if.cmd_data_i  = d;
        #1;
        while (!bus_if.cmd_ready_o && n < 100) begin
            tick();
            #1;
            n++;
        end
        c0 = cyc;
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL cmd_accept_timeout op=%0d", op);
        end
        tick();
        bus_if.cmd_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(bus_if.cmd_ready_o && bus_q.size() == 0 && rsp_q.size() == 0) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout bus_pending=%0d rsp_pending=%0d", bus_q.size(), rsp_q.size());
        end
    endtask

    // Register-file model: each read strobe consumes the next queued byte
    always @(negedge clk) begin
        if (bus_if.read_o) begin
            if (rd_q.size() > 0) bus_if.rdata_i <= rd_q.pop_front();
            else                 bus_if.rdata_i <= 8'h00;
        end
    end

    // Bus strobe monitor
    always @(negedge clk) begin
        if (bus_if.write_o || bus_if.read_o) begin
            checks++;
            if (bus_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe cyc=%0d actual wr=%0b rd=%0b addr=%0d data=%h required none",
                         cyc, bus_if.write_o, bus_if.read_o, bus_if.address_o, bus_if.wdata_o);
            end else begin
                mon_b = bus_q.pop_front();
                if (cyc != mon_b.cyc || bus_if.write_o !== mon_b.wr || bus_if.read_o !== !mon_b.wr ||
                    bus_if.address_o !== mon_b.addr || bus_if.wdata_o !== mon_b.data) begin
                    failures++;
                    $display("FAIL bus_strobe actual cyc=%0d wr=%0b rd=%0b addr=%0d data=%h required cyc=%0d wr=%0b addr=%0d data=%h",
                             cyc, bus_if.write_o, bus_if.read_o, bus_if.address_o, bus_if.wdata_o,
                             mon_b.cyc, mon_b.wr, mon_b.addr, mon_b.data);
                end
            end
        end
    end

    // Response monitor: compares on each completed handshake
    always @(negedge clk) begin
        if (bus_if.rsp_valid_o && bus_if.rsp_ready_i) begin
            checks++;
            if (rsp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_rsp cyc=%0d actual data=%h err=%b irq=%0b required none",
                         cyc, bus_if.rsp_data_o, bus_if.rsp_err_o, bus_if.rsp_irq_o);
            end else begin
                mon_r = rsp_q.pop_front();
                if (cyc != mon_r.cyc || bus_if.rsp_data_o !== mon_r.data ||
                    bus_if.rsp_err_o !== mon_r.err || bus_if.rsp_irq_o !== mon_r.irq) begin
                    failures++;
                    $display("FAIL rsp actual cyc=%0d data=%h err=%b irq=%0b required cyc=%0d data=%h err=%b irq=%0b",
                             cyc, bus_if.rsp_data_o, bus_if.rsp_err_o, bus_if.rsp_irq_o,
                             mon_r.cyc, mon_r.data, mon_r.err, mon_r.irq);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        bus_if.cmd_valid_i = 1'b0;
        bus_if.cmd_op_i    = OP_CONFIG;
        bus_if.cmd_data_i  = '0;
        bus_if.rdata_i     = '0;
        bus_if.irq_i       = 1'b0;
        bus_if.rsp_ready_i = 1'b1;

        // Reset state
        repeat (3) tick();
        chk("rst_write", 32'(bus_if.write_o), 32'd0);
        chk("rst_read", 32'(bus_if.read_o), 32'd0);
        chk("rst_cmd_ready", 32'(bus_if.cmd_ready_o), 32'd0);
        chk("rst_rsp_valid", 32'(bus_if.rsp_valid_o), 32'd0);
        chk("rst_addr", 32'(bus_if.address_o), 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_ready_same_cycle", 32'(bus_if.cmd_ready_o), 32'd0);
        tick();
        chk("rel_ready_next_cycle", 32'(bus_if.cmd_ready_o), 32'd1);

        // CONFIG STR=2D div=0145
        issue(OP_CONFIG, 24'h2D0145, c0);
        push_bus(c0 + 1, 1'b1, 3'd1, 8'h45);
        push_bus(c0 + 2, 1'b1, 3'd2, 8'h01);
        push_bus(c0 + 3, 1'b1, 3'd0, 8'h2D);
        while (cyc < c0 + 3) tick();
        chk("cfg_ready_c3", 32'(bus_if.cmd_ready_o), 32'd0);
        tick();
        chk("cfg_ready_c4", 32'(bus_if.cmd_ready_o), 32'd1);
        wait_idle();

        // SEND A5 with TX FIFO full for two polls
        rd_q.push_back(8'h80); rd_q.push_back(8'h80); rd_q.push_back(8'h00);
        issue(OP_SEND, 24'h0000A5, c0);
        push_bus(c0 + 1, 1'b0, 3'd3, 8'h00);
        push_bus(c0 + 3, 1'b0, 3'd3, 8'h00);
        push_bus(c0 + 5, 1'b0, 3'd3, 8'h00);
        push_bus(c0 + 7, 1'b1, 3'd7, 8'hA5);
        wait_idle();

        // SEND with FIFO stuck full: timeout after POLL_LIMIT reads
        repeat (4) rd_q.push_back(8'h80);
        issue(OP_SEND, 24'h000077, c0);
        push_bus(c0 + 1, 1'b0, 3'd3, 8'h00);
        push_bus(c0 + 3, 1'b0, 3'd3, 8'h00);
        push_bus(c0 + 5, 1'b0, 3'd3, 8'h00);
        push_bus(c0 + 7, 1'b0, 3'd3, 8'h00);
        push_rsp(c0 + 9, 8'h00, 4'b1000, 1'b0);
        wait_idle();

        // Interrupt with RXRDY and parity error
        tick();
        bus_if.irq_i = 1'b1;
        c0 = cyc;
        rd_q.push_back(8'hA0); rd_q.push_back(8'h3C);
        push_bus(c0 + 1, 1'b0, 3'd5, 8'h00);
        push_bus(c0 + 3, 1'b0, 3'd6, 8'h00);
        push_bus(c0 + 5, 1'b1, 3'd5, 8'h01);
        push_rsp(c0 + 6, 8'h3C, 4'b0010, 1'b1);
        #1;
        chk("irq_blocks_ready", 32'(bus_if.cmd_ready_o), 32'd0);
        tick();
        bus_if.irq_i = 1'b0;
        wait_idle();

        // irq and command together: ISR (framing, no data) first, then THRESHOLD
        tick();
        bus_if.irq_i       = 1'b1;
        bus_if.cmd_valid_i = 1'b1;
        bus_if.cmd_op_i    = OP_THRESHOLD;
        bus_if.cmd_data_i  = 24'h00002A;
        c0 = cyc;
        rd_q.push_back(8'h40);
        push_bus(c0 + 1, 1'b0, 3'd5, 8'h00);
        push_bus(c0 + 3, 1'b1, 3'd5, 8'h01);
        push_rsp(c0 + 4, 8'h00, 4'b0100, 1'b1);
        push_bus(c0 + 6, 1'b1, 3'd3, 8'h2A);
        #1;
        chk("both_ready_low", 32'(bus_if.cmd_ready_o), 32'd0);
        tick();
        bus_if.irq_i = 1'b0;
        while (cyc < c0 + 5) tick();
        chk("both_cmd_accept_c5", 32'(bus_if.cmd_ready_o), 32'd1);
        tick();
        bus_if.cmd_valid_i = 1'b0;
        wait_idle();

        // READ with response back-pressure
        bus_if.rsp_ready_i = 1'b0;
        rd_q.push_back(8'h9E);
        issue(OP_READ, 24'h000000, c0);
        push_bus(c0 + 1, 1'b0, 3'd6, 8'h00);
        push_rsp(c0 + 5, 8'h9E, 4'b0000, 1'b0);
        while (cyc < c0 + 2) tick();
        chk("read_valid_c2", 32'(bus_if.rsp_valid_o), 32'd0);
        tick();
        chk("read_valid_c3", 32'(bus_if.rsp_valid_o), 32'd1);
        tick();
        chk("read_stall_data", 32'(bus_if.rsp_data_o), 32'h9E);
        tick();
        bus_if.rsp_ready_i = 1'b1;
        tick();
        chk("read_done_valid", 32'(bus_if.rsp_valid_o), 32'd0);
        wait_idle();

        // Reset in the middle of a CONFIG, during the UDVR write
        issue(OP_CONFIG, 24'h123456, c0);
        push_bus(c0 + 1, 1'b1, 3'd1, 8'h56);
        push_bus(c0 + 2, 1'b1, 3'd2, 8'h34);
        while (cyc < c0 + 2) tick();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_write", 32'(bus_if.write_o), 32'd0);
        chk("midrst_addr", 32'(bus_if.address_o), 32'd0);
        chk("midrst_wdata", 32'(bus_if.wdata_o), 32'd0);
        chk("midrst_ready", 32'(bus_if.cmd_ready_o), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_rel_ready0", 32'(bus_if.cmd_ready_o), 32'd0);
        tick();
        chk("midrst_rel_ready1", 32'(bus_if.cmd_ready_o), 32'd1);

        repeat (6) tick();
        chk("end_bus_pending", 32'(bus_q.size()), 32'd0);
        chk("end_rsp_pending", 32'(rsp_q.size()), 32'd0);
        chk("end_rdata_pending", 32'(rd_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_host_sequencer.md
# uart_host_sequencer

Hardware register-bus master for the UART controller: the initiator side of the controller's 8-register map (STR, LDVR, UDVR, FSR, CTR, ISR, RXR, TXR). It accepts high-level commands over a valid/ready port and converts them into register read/write sequences. It also services the controller interrupt by reading ISR, fetching RX data and acknowledging. It sits between an on-chip client (or test harness) and the UART register file.

## Interface
Parameters:
- POLL_LIMIT, 255: maximum FSR reads while TXF=1 before a send aborts.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_op_i  in  2  0 CONFIG, 1 SEND, 2 THRESHOLD, 3 READ
- cmd_data_i  in  24  CONFIG: {STR[7:0], divisor[15:0]}; SEND: [7:0] byte; THRESHOLD: [5:0]
- address_o  out  3  register address
- write_o  out  1  single-cycle write strobe
- read_o  out  1  single-cycle read strobe
- wdata_o  out  8  write data
- rdata_i  in  8  read data, valid the cycle after read_o
- irq_i  in  1  controller interrupt, level
- rsp_valid_o  out  1  response pending
- rsp_ready_i  in  1  response consumed
- rsp_data_o  out  8  RXR byte
- rsp_irq_o  out  1  response produced by interrupt service
- rsp_err_o  out  4  {TIMEOUT, FRM, PAR, OVR}

## Operation
- States: IDLE, WR_LDVR, WR_UDVR, WR_STR, RD_FSR, CHK_FSR, WR_TXR, WR_FSR, RD_RXR, CHK_RXR, RD_ISR, CHK_ISR, ACK_ISR, RESP.
- IDLE priority: irq_i=1 -> RD_ISR (command not accepted); else cmd_valid_i -> command. cmd_ready_o = IDLE & ~irq_i. Command fields latched on acceptance.
- CONFIG: WR_LDVR (divisor[7:0], addr 1) -> WR_UDVR (divisor[15:8], addr 2) -> WR_STR (addr 0) -> IDLE. No response.
- THRESHOLD: WR_FSR writes {2'b00, thr} to addr 3 -> IDLE. No response.
- SEND: RD_FSR -> CHK_FSR; TXF (bit 7)=0 -> WR_TXR (addr 7) -> IDLE, no response; TXF=1 -> increment poll counter, back to RD_FSR; at POLL_LIMIT polls -> RESP with err=4'b1000, data 0.
- READ: RD_RXR (addr 6) -> CHK_RXR latches rdata_i -> RESP, rsp_irq_o=0, err 0.
- IRQ: RD_ISR (addr 5) -> CHK_ISR latches FRM/PAR/OVR (bits 6/5/4); RXRDY (bit 7)=1 -> RD_RXR -> CHK_RXR -> ACK_ISR; else ACK_ISR directly (data 0). ACK_ISR writes 8'h01 (IACK) to addr 5 -> RESP with rsp_irq_o=1.
- RESP: rsp_valid_o held with stable data/flags until rsp_ready_i; then IDLE.
- Poll counter 8 bits, cleared on every command acceptance; saturates, no wrap.

## Timing
- Reset: state IDLE; all outputs 0 (cmd_ready_o rises first cycle after reset release if irq_i=0); latches and counter cleared.
- Strobes: exactly one of read_o/write_o asserted for exactly one cycle per bus state; address_o/wdata_o valid in the same cycle; 0 otherwise.
- CONFIG accepted at cycle 0: writes in cycles 1, 2, 3; cmd_ready_o high cycle 4.
- SEND with TXF=0: read at 1, check at 2, write at 3, ready at 4. Each extra poll adds 2 cycles.
- READ: read at 1, sample at 2, rsp_valid_o at 3.
- IRQ with RXRDY: ISR read 1, check 2, RXR read 3, sample 4, ack write 5, rsp_valid_o 6.
- irq_i is sampled only in IDLE; irq assertion mid-command does not pre-empt. irq_i still high after RESP (controller not yet deasserted) re-enters service; acceptable.
- Reset mid-sequence aborts immediately; no strobe issued in the reset cycle or after.

## Structure
- Shared package (alongside the register package): command opcode enum, response error bit indices, register address constants reused, ISR/FSR field positions from existing packed structs.
- Single module; no sub-module needed. Poll counter inline.

## Test plan
- CONFIG {STR=8'h2D, div=16'h0145} -> writes (1,8'h45),(2,8'h01),(0,8'h2D) in consecutive cycles; ready at cycle 4.
- SEND 8'hA5, FSR returns 8'h80 twice then 8'h00 -> three FSR reads, then write (7,8'hA5); no response.
- SEND with FSR stuck at 8'h80, POLL_LIMIT=4 -> 4 reads, rsp err=4'b1000, no TXR write.
- irq_i=1 with ISR=8'hA0, RXR=8'h3C -> rsp data 8'h3C, err 4'b0010, rsp_irq_o=1, ack write (5,8'h01).
- irq_i and cmd_valid_i rise same cycle -> cmd_ready_o=0, ISR serviced first, command accepted after RESP handshake.
- rst_i pulsed during WR_UDVR -> strobes drop within same cycle, no WR_STR; outputs 0.
